// File: rtl/updated_key_expansion.sv
// AES-256 key schedule: emits round keys rk0..rk14 on out_key, one per clock,
// starting at the first rising edge after reset release. The 256-bit key is
// sampled once on that first edge. All later rounds derive from an 8-word
// sliding window that holds the most recent eight schedule words.
module updated_key_expansion (
  input  logic         clk,
  input  logic         rst,      // asynchronous, active-low
  input  logic [255:0] key,
  output logic [127:0] out_key
);

  // AES S-box (FIPS-197 Fig. 7), row-major, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Combinational S-box lookup for one byte.
  function automatic logic [7:0] f_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  logic [255:0] r_sched;   // w[i-8]..w[i-1], oldest word in the top 32 bits
  logic [3:0]   r_cnt;     // index of the round key produced on the next edge
  logic [127:0] r_out_key;

  logic [31:0]  w_oldest;
  logic [31:0]  w_last;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [7:0]   w_rc;
  logic [31:0]  w_t;
  logic [31:0]  w_new0;
  logic [31:0]  w_new1;
  logic [31:0]  w_new2;
  logic [31:0]  w_new3;

  assign w_oldest = r_sched[255:224];
  assign w_last   = r_sched[31:0];

  // Even round index means the new group starts at i mod 8 = 0 (RotWord + Rcon);
  // odd means i mod 8 = 4 (SubWord only). Both share the same four S-boxes.
  assign w_sub_in = r_cnt[0] ? w_last : {w_last[23:0], w_last[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign w_sub_out[gi*8 +: 8] = f_sbox(w_sub_in[gi*8 +: 8]);
    end
  endgenerate

  // Rcon index is i/8 = n/2 for even round n, giving 01,02,04,...,40.
  assign w_rc = 8'd1 << (r_cnt[3:1] - 3'd1);

  assign w_t    = r_cnt[0] ? w_sub_out : (w_sub_out ^ {w_rc, 24'h0});
  assign w_new0 = w_oldest ^ w_t;
  assign w_new1 = r_sched[223:192] ^ w_new0;
  assign w_new2 = r_sched[191:160] ^ w_new1;
  assign w_new3 = r_sched[159:128] ^ w_new2;

  // Round sequencer: sample key, emit its halves, then slide the window one
  // round key per cycle until rk14, after which everything holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sched   <= '0;
      r_cnt     <= '0;
      r_out_key <= '0;
    end else begin
      case (r_cnt)
        4'd0: begin
          r_sched   <= key;
          r_out_key <= key[255:128];
          r_cnt     <= 4'd1;
        end
        4'd1: begin
          r_out_key <= r_sched[127:0];
          r_cnt     <= 4'd2;
        end
        4'd15: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_sched   <= {r_sched[127:0], w_new0, w_new1, w_new2, w_new3};
          r_out_key <= {w_new0, w_new1, w_new2, w_new3};
          r_cnt     <= r_cnt + 4'd1;
        end
      endcase
    end
  end

  assign out_key = r_out_key;

endmodule

// File: tb/tb_updated_key_expansion.sv
// Directed bench for updated_key_expansion: reset behaviour, the FIPS-197 C.3
// AES-256 schedule, hold after rk14, mid-sequence reset and key changes.
module tb_updated_key_expansion;

  logic         clk;
  logic         rst;
  logic [255:0] key;
  logic [127:0] out_key;

  int n_vec;
  int n_err;

  logic [127:0] fips_rk [0:14];

  localparam logic [255:0] KEY_A =
    256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
  localparam logic [255:0] KEY_FIPS =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  updated_key_expansion dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .out_key (out_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  initial begin
    fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    fips_rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    fips_rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    fips_rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    fips_rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    fips_rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    fips_rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    fips_rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    fips_rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    fips_rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    fips_rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    fips_rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    fips_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    fips_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    key   = KEY_A;

    // Reset held while the clock runs: output stays zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_vec($sformatf("rst_hold%0d", i), out_key, 128'h0);
    end

    // Release between edges: nothing changes until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vec("release_no_edge", out_key, 128'h0);

    // First three round keys of KEY_A.
    @(posedge clk); #1;
    check_vec("A_rk0", out_key, 128'h642423baa95efb4362d3f2ce993c0904);
    @(posedge clk); #1;
    check_vec("A_rk1", out_key, 128'h150f258aa1fe796841d7b4429c9b5a30);
    @(posedge clk); #1;
    check_vec("A_rk2", out_key, 128'h719a2764d8c4dc27ba172ee9232b27ed);

    // Run to edge 6, then assert reset between edges: output clears at once.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_vec("midseq_async_clear", out_key, 128'h0);
    @(posedge clk); #1;
    check_vec("midseq_held", out_key, 128'h0);

    // Restart with the FIPS-197 C.3 key.
    @(negedge clk);
    key = KEY_FIPS;
    rst = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      check_vec($sformatf("fips_rk%0d", n), out_key, fips_rk[n]);
      // Key changes after the first edge must be ignored.
      if (n == 0) key = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
    end

    // Sequence holds at rk14 afterwards.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_vec($sformatf("hold_rk14_%0d", i), out_key, fips_rk[14]);
    end

    // A fresh reset restarts at rk0 of whatever key is present then.
    @(negedge clk);
    rst = 1'b0;
    key = KEY_A;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_vec("restart_rk0", out_key, 128'h642423baa95efb4362d3f2ce993c0904);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
